// File: rtl/sev7seg_pkg.sv
// rtl/sev7seg_pkg.sv - shared segment constants and scan phase type for the 7-segment scan driver
package sev7seg_pkg;

    // All-segments-off pattern in active-low form.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns indexed by hex digit; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h38, 7'h30, 7'h42, 7'h31,   // F E D C
        7'h60, 7'h08, 7'h0C, 7'h00,   // B A 9 8
        7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
        7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
    };

    // A slot opens with all digits dark, then drives the selected digit.
    typedef enum logic {
        PH_DEAD  = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_LUT[hex];
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - combinational hex to active-low 7-segment decode with blanking
module seg7_hex_lut
    import sev7seg_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over the digit value so suppressed digits stay dark.
    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            seg_o = hex_to_seg(hex_i);
        end
    end

endmodule

// File: rtl/sev7seg_scan_mux.sv
// rtl/sev7seg_scan_mux.sv - time-multiplexed N-digit 7-segment scan driver with dead time and leading-zero blanking
module sev7seg_scan_mux
    import sev7seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL_LOW = (ACTIVE_LOW != 0);

    // Off state at the pins, already in board polarity.
    localparam logic [6:0]            SEG_IDLE = POL_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic                  DP_IDLE  = POL_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    phase_e                  phase;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic [3:0]              cur_hex;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [6:0]              seg_al;
    logic                    dp_al;
    logic [NUM_DIGITS-1:0]   an_al;

    // Shadow capture is independent of en so software can preload a dark display.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (load) begin
            shadow_data_d = data;
            shadow_dp_d   = dp;
        end
    end

    // Slot counter and digit index advance only while scanning; en=0 freezes both.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_d = '0;
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Phase decode and leading-zero mask: digit i is blanked when it and all digits above it are zero.
    always_comb begin
        phase   = (cnt_q < CNT_W'(DEAD_CYCLES)) ? PH_DEAD : PH_DRIVE;
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run & (shadow_data_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run;
        end
        cur_hex        = shadow_data_q[{idx_q, 2'b00} +: 4];
        an_sel         = '0;
        an_sel[idx_q]  = 1'b1;
    end

    seg7_hex_lut u_lut (
        .hex_i   (cur_hex),
        .blank_i (blank_lz & lz_mask[idx_q]),
        .seg_o   (cur_seg)
    );

    // Next output word in active-low form, then flipped to board polarity before the output registers.
    always_comb begin
        seg_al = SEG_OFF;
        dp_al  = 1'b1;
        an_al  = {NUM_DIGITS{1'b1}};
        if (en && (phase == PH_DRIVE)) begin
            seg_al = cur_seg;
            dp_al  = ~shadow_dp_q[idx_q];
            an_al  = ~an_sel;
        end
        seg_d = POL_LOW ? seg_al : ~seg_al;
        dp_d  = POL_LOW ? dp_al  : ~dp_al;
        an_d  = POL_LOW ? an_al  : ~an_al;
    end

    // All state, with outputs forced to the off state the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            seg_q         <= SEG_IDLE;
            dp_q          <= DP_IDLE;
            an_q          <= AN_IDLE;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg    = seg_q;
    assign dp_out = dp_q;
    assign an     = an_q;

endmodule

// File: tb/tb_sev7seg_scan_mux.sv
// tb/tb_sev7seg_scan_mux.sv - directed self-checking bench for sev7seg_scan_mux in both polarities
module tb_sev7seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [6:0]  seg_l, seg_h;
    logic        dp_l, dp_h;
    logic [3:0]  an_l, an_h;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sev7seg_scan_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .ACTIVE_LOW(1)
    ) dut_low (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .seg(seg_l), .dp_out(dp_l), .an(an_l)
    );

    sev7seg_scan_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .ACTIVE_LOW(0)
    ) dut_high (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .seg(seg_h), .dp_out(dp_h), .an(an_h)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected values are given in active-low form; the active-high instance must show their inverse.
    task automatic chk(input string tag, input logic [6:0] es, input logic ed, input logic [3:0] ea);
        logic [6:0] es_n;
        logic       ed_n;
        logic [3:0] ea_n;
        es_n = ~es;
        ed_n = ~ed;
        ea_n = ~ea;
        checks++;
        assert ({seg_l, dp_l, an_l} === {es, ed, ea}) else begin
            failures++;
            $error("FAIL %s low: seg=%h dp=%b an=%b expected seg=%h dp=%b an=%b",
                   tag, seg_l, dp_l, an_l, es, ed, ea);
        end
        checks++;
        assert ({seg_h, dp_h, an_h} === {es_n, ed_n, ea_n}) else begin
            failures++;
            $error("FAIL %s high: seg=%h dp=%b an=%b expected seg=%h dp=%b an=%b",
                   tag, seg_h, dp_h, an_h, es_n, ed_n, ea_n);
        end
    endtask

    // One full slot: two dead cycles then six drive cycles on the given digit.
    task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        for (int i = 0; i < 2; i++) begin
            step();
            chk({tag, " dead"}, 7'h7F, 1'b1, 4'hF);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk({tag, " drive"}, es, ed, ea);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; data = 16'h0; dp = 4'h0; blank_lz = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 chk("reset async", 7'h7F, 1'b1, 4'hF);
        step(); chk("reset held", 7'h7F, 1'b1, 4'hF);
        step(); chk("reset held2", 7'h7F, 1'b1, 4'hF);
        rst = 1'b0;

        // Load 1234 while dark, then scan
        data = 16'h1234; dp = 4'h0; load = 1'b1;
        step(); chk("load dark", 7'h7F, 1'b1, 4'hF);
        load = 1'b0; en = 1'b1;
        slot("d0 '4'", 4'b1110, 7'h4C, 1'b1);
        slot("d1 '3'", 4'b1101, 7'h06, 1'b1);
        slot("d2 '2'", 4'b1011, 7'h12, 1'b1);
        slot("d3 '1'", 4'b0111, 7'h4F, 1'b1);
        slot("d0 wrap", 4'b1110, 7'h4C, 1'b1);

        // en gating mid-slot on digit 1 (cnt reaches 4 then freezes)
        step(); chk("pre-gate dead", 7'h7F, 1'b1, 4'hF);
        step(); chk("pre-gate dead2", 7'h7F, 1'b1, 4'hF);
        step(); chk("pre-gate d1", 7'h06, 1'b1, 4'b1101);
        step(); chk("pre-gate d1b", 7'h06, 1'b1, 4'b1101);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); chk("gated off", 7'h7F, 1'b1, 4'hF);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk("resume d1", 7'h06, 1'b1, 4'b1101);
        end
        slot("after resume d2", 4'b1011, 7'h12, 1'b1);

        // Input change without load must not reach the display
        data = 16'h5678;
        slot("no-load d3", 4'b0111, 7'h4F, 1'b1);
        step(); chk("no-load dead", 7'h7F, 1'b1, 4'hF);
        step(); chk("no-load dead2", 7'h7F, 1'b1, 4'hF);
        step(); chk("no-load d0", 7'h4C, 1'b1, 4'b1110);
        load = 1'b1;
        step(); chk("load edge old", 7'h4C, 1'b1, 4'b1110);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("load new d0 '8'", 7'h00, 1'b1, 4'b1110);
        end
        slot("new d1 '7'", 4'b1101, 7'h0F, 1'b1);

        // Leading-zero blanking with 0070 and dp on digit 3
        en = 1'b0; data = 16'h0070; dp = 4'b1000; blank_lz = 1'b1; load = 1'b1;
        step(); chk("lz load dark", 7'h7F, 1'b1, 4'hF);
        load = 1'b0; en = 1'b1;
        slot("lz d2 blank", 4'b1011, 7'h7F, 1'b1);
        slot("lz d3 blank dp", 4'b0111, 7'h7F, 1'b0);
        slot("lz d0 '0'", 4'b1110, 7'h01, 1'b1);
        slot("lz d1 '7'", 4'b1101, 7'h0F, 1'b1);
        blank_lz = 1'b0;
        slot("nolz d2 '0'", 4'b1011, 7'h01, 1'b1);
        slot("nolz d3 '0' dp", 4'b0111, 7'h01, 1'b0);

        // Decode of C..F in both polarities
        en = 1'b0; data = 16'hFEDC; dp = 4'h0; load = 1'b1;
        step(); chk("fedc load dark", 7'h7F, 1'b1, 4'hF);
        load = 1'b0; en = 1'b1;
        slot("d0 'C'", 4'b1110, 7'h31, 1'b1);
        slot("d1 'D'", 4'b1101, 7'h42, 1'b1);
        slot("d2 'E'", 4'b1011, 7'h30, 1'b1);
        slot("d3 'F'", 4'b0111, 7'h38, 1'b1);

        // Reset mid-slot during a drive phase
        step(); chk("pre-rst dead", 7'h7F, 1'b1, 4'hF);
        step(); chk("pre-rst dead2", 7'h7F, 1'b1, 4'hF);
        step(); chk("pre-rst drive", 7'h31, 1'b1, 4'b1110);
        #2 rst = 1'b1;
        #1 chk("rst mid-slot", 7'h7F, 1'b1, 4'hF);
        step(); chk("rst held en", 7'h7F, 1'b1, 4'hF);
        rst = 1'b0;
        slot("post-rst d0 cleared", 4'b1110, 7'h01, 1'b1);
        slot("post-rst d1 cleared", 4'b1101, 7'h01, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
